// File: rtl/enemy_rom_arbiter.sv
// Round-robin arbiter with bounded bursts in front of the shared enemy sprite ROM.
// Returns the palette index one cycle after the grant, tagged with the owning requester ID.
module enemy_rom_arbiter #(
    parameter int                NUM_REQ   = 4,
    parameter int                ID_W      = 2,
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 4,
    parameter int                ROM_DEPTH = 3072,
    parameter int                MAX_BURST = 8,
    parameter logic [DATA_W-1:0] OOR_DATA  = 4'h0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      oor_err
);

    localparam int                BCNT_W      = $clog2(MAX_BURST) + 1;
    localparam logic [BCNT_W-1:0] BURST_LAST  = BCNT_W'(MAX_BURST - 1);
    localparam logic [31:0]       ROM_DEPTH_U = 32'(ROM_DEPTH);
    localparam logic [ID_W-1:0]   LAST_ID     = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [BCNT_W-1:0] burst_cnt;
    logic              locked;
    logic              v_q;
    logic [ID_W-1:0]   id_q;
    logic              oor_q;

    logic              win_found;
    logic              cont;
    logic [ID_W-1:0]   win_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              win_oor;
    logic [ID_W:0]     scan;

    // First requester at or after start, wrapping; MSB of the result flags a hit.
    function automatic logic [ID_W:0] rr_scan(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    start);
        logic            found;
        logic [ID_W-1:0] id;
        int              c;
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(start) + k) % NUM_REQ;
            if (!found && r[c]) begin
                found = 1'b1;
                id    = ID_W'(c);
            end
        end
        return {found, id};
    endfunction

    always_comb begin
        cont      = 1'b0;
        scan      = rr_scan(req, ptr);
        win_found = scan[ID_W];
        win_id    = scan[ID_W-1:0];
        if (locked && req[owner] && (burst_cnt < BURST_LAST)) begin
            cont      = 1'b1;
            win_found = 1'b1;
            win_id    = owner;
        end
        // Outputs must stay quiet while reset is held even if requests are present.
        if (!Reset) begin
            cont      = 1'b0;
            win_found = 1'b0;
            win_id    = '0;
        end
    end

    always_comb begin
        sel_addr = req_addr[win_id*ADDR_W +: ADDR_W];
        win_oor  = (32'(sel_addr) >= ROM_DEPTH_U);
        gnt      = '0;
        rom_addr = '0;
        if (win_found) begin
            gnt[win_id] = 1'b1;
            if (!win_oor)
                rom_addr = sel_addr;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            locked    <= 1'b0;
            v_q       <= 1'b0;
            id_q      <= '0;
            oor_q     <= 1'b0;
        end else begin
            if (cont) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else if (win_found) begin
                owner     <= win_id;
                burst_cnt <= '0;
                locked    <= 1'b1;
                ptr       <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
            end else begin
                locked    <= 1'b0;
            end
            v_q   <= win_found;
            id_q  <= win_id;
            oor_q <= win_found & win_oor;
        end
    end

    always_comb begin
        rd_valid = v_q;
        rd_id    = v_q ? id_q : '0;
        rd_data  = (v_q && !oor_q) ? rom_data : OOR_DATA;
        oor_err  = v_q & oor_q;
    end

endmodule

// File: tb/tb_enemy_rom_arbiter.sv
// Directed bench for enemy_rom_arbiter with a registered ROM model holding mem[a] = a[3:0].
module tb_enemy_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  req = '0;
    logic [47:0] req_addr = '0;
    logic [3:0]  gnt;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [3:0]  rd_data;
    logic        oor_err;

    int checks = 0;
    int errors = 0;

    enemy_rom_arbiter dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_addr(rom_addr), .rom_data(rom_data), .rd_valid(rd_valid),
        .rd_id(rd_id), .rd_data(rd_data), .oor_err(oor_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_addr[3:0];

    function automatic logic [11:0] a3(input int i);
        return 12'(i * 100 + 5);
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        req   = '0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        req   = 4'b1111;
        req_addr = {12'd40, 12'd30, 12'd20, 12'd10};
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk); #1;
            checks++;
            if (gnt !== 4'b0 || rom_addr !== 12'd0 || rd_valid !== 1'b0 ||
                rd_id !== 2'd0 || rd_data !== 4'h0 || oor_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got gnt=%b addr=%0d v=%b id=%0d d=%0h oor=%b exp all zero",
                         gnt, rom_addr, rd_valid, rd_id, rd_data, oor_err);
            end
        end
        @(negedge Clk);
        Reset = 1'b1;
        req   = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk); #1;
            checks++;
            if (gnt !== 4'b0 || rom_addr !== 12'd0 || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset got gnt=%b addr=%0d v=%b exp 0 0 0",
                         gnt, rom_addr, rd_valid);
            end
        end
    endtask

    task automatic test_single_stream();
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            @(negedge Clk);
            req = (i < 10) ? 4'b0001 : 4'b0000;
            req_addr[11:0] = 12'(i);
            #1;
            checks++;
            if (gnt !== ((i < 10) ? 4'b0001 : 4'b0000) || rom_addr !== ((i < 10) ? 12'(i) : 12'd0)) begin
                errors++;
                $display("FAIL stream_grant[%0d] got gnt=%b addr=%0d exp gnt=0001 addr=%0d",
                         i, gnt, rom_addr, i);
            end
            if (i > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_id !== 2'd0 || rd_data !== 4'(i - 1) || oor_err !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_read[%0d] got v=%b id=%0d d=%0h exp v=1 id=0 d=%0h",
                             i, rd_valid, rd_id, rd_data, 4'(i - 1));
                end
            end
        end
    endtask

    task automatic test_burst_rotation();
        int          w;
        int          prev;
        logic [11:0] pa;
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i*12 +: 12] = a3(i);
        prev = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            req = 4'b1111;
            #1;
            w = (c / 8) % 4;
            checks++;
            if (gnt !== 4'(1 << w) || rom_addr !== a3(w)) begin
                errors++;
                $display("FAIL burst_grant[%0d] got gnt=%b addr=%0d exp gnt=%b addr=%0d",
                         c, gnt, rom_addr, 4'(1 << w), a3(w));
            end
            if (c > 0) begin
                pa = a3(prev);
                checks++;
                if (rd_valid !== 1'b1 || rd_id !== 2'(prev) || rd_data !== pa[3:0]) begin
                    errors++;
                    $display("FAIL burst_read[%0d] got v=%b id=%0d d=%0h exp v=1 id=%0d d=%0h",
                             c, rd_valid, rd_id, rd_data, prev, pa[3:0]);
                end
            end
            prev = w;
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        req_addr[2*12 +: 12] = 12'd3071;
        @(negedge Clk);
        req = 4'b0100;
        #1;
        checks++;
        if (gnt !== 4'b0100 || rom_addr !== 12'd3071) begin
            errors++;
            $display("FAIL oor_last_valid got gnt=%b addr=%0d exp gnt=0100 addr=3071", gnt, rom_addr);
        end
        @(negedge Clk);
        req_addr[2*12 +: 12] = 12'd3072;
        #1;
        checks++;
        if (gnt !== 4'b0100 || rom_addr !== 12'd0 || rd_valid !== 1'b1 ||
            rd_data !== 4'hF || oor_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_edge got gnt=%b addr=%0d v=%b d=%0h oor=%b exp 0100 0 1 f 0",
                     gnt, rom_addr, rd_valid, rd_data, oor_err);
        end
        @(negedge Clk);
        req = 4'b0000;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_id !== 2'd2 || rd_data !== 4'h0 || oor_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read got v=%b id=%0d d=%0h oor=%b exp 1 2 0 1",
                     rd_valid, rd_id, rd_data, oor_err);
        end
        @(negedge Clk); #1;
        checks++;
        if (rd_valid !== 1'b0 || oor_err !== 1'b0 || rd_data !== 4'h0) begin
            errors++;
            $display("FAIL oor_idle got v=%b oor=%b d=%0h exp 0 0 0", rd_valid, oor_err, rd_data);
        end
    endtask

    task automatic test_drop_mid_burst();
        do_reset();
        req_addr[1*12 +: 12] = 12'h011;
        req_addr[3*12 +: 12] = 12'h033;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            req = 4'b0010;
            #1;
            checks++;
            if (gnt !== 4'b0010) begin
                errors++;
                $display("FAIL drop_pre[%0d] got gnt=%b exp 0010", k, gnt);
            end
        end
        @(negedge Clk);
        checks++;
        if (dut.burst_cnt !== 4'd3) begin
            errors++;
            $display("FAIL drop_cnt_before got %0d exp 3", dut.burst_cnt);
        end
        req = 4'b1000;
        #1;
        checks++;
        if (gnt !== 4'b1000 || rom_addr !== 12'h033) begin
            errors++;
            $display("FAIL drop_switch got gnt=%b addr=%0h exp gnt=1000 addr=33", gnt, rom_addr);
        end
        @(posedge Clk); #1;
        checks++;
        if (dut.burst_cnt !== 4'd0 || dut.ptr !== 2'd0 || dut.owner !== 2'd3) begin
            errors++;
            $display("FAIL drop_state got cnt=%0d ptr=%0d owner=%0d exp 0 0 3",
                     dut.burst_cnt, dut.ptr, dut.owner);
        end
        @(negedge Clk);
        req = 4'b0000;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_id !== 2'd3 || rd_data !== 4'h3) begin
            errors++;
            $display("FAIL drop_read got v=%b id=%0d d=%0h exp 1 3 3", rd_valid, rd_id, rd_data);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        req_addr[1*12 +: 12] = 12'd7;
        req_addr[3*12 +: 12] = 12'd9;
        @(negedge Clk);
        req = 4'b1000;
        @(posedge Clk); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_id !== 2'd3) begin
            errors++;
            $display("FAIL inflight_pending got v=%b id=%0d exp 1 3", rd_valid, rd_id);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_id !== 2'd0 || gnt !== 4'b0 || dut.ptr !== 2'd0) begin
            errors++;
            $display("FAIL inflight_reset got v=%b id=%0d gnt=%b ptr=%0d exp 0 0 0000 0",
                     rd_valid, rd_id, gnt, dut.ptr);
        end
        @(negedge Clk);
        Reset = 1'b1;
        req   = 4'b1010;
        #1;
        checks++;
        if (gnt !== 4'b0010 || rom_addr !== 12'd7) begin
            errors++;
            $display("FAIL inflight_restart got gnt=%b addr=%0d exp gnt=0010 addr=7", gnt, rom_addr);
        end
        @(negedge Clk);
        req = 4'b0000;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_id !== 2'd1 || rd_data !== 4'h7) begin
            errors++;
            $display("FAIL inflight_read got v=%b id=%0d d=%0h exp 1 1 7", rd_valid, rd_id, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_burst_rotation();
        test_out_of_range();
        test_drop_mid_burst();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
